// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB + 2-bit counter branch predictor.
// Counter encodings, fall-through offset and PC field slicing live here.
package bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_e;

    localparam logic [31:0] FALL_THRU_OFS = 32'd8;

    function automatic logic [31:0] pc_field(
        input logic [31:0] pc,
        input int unsigned lsb,
        input int unsigned width
    );
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (pc >> lsb) & mask;
    endfunction

    function automatic ctr_e ctr_step(
        input ctr_e c,
        input logic taken
    );
        ctr_e n;
        n = c;
        if (taken) begin
            if (c != CTR_ST)
                n = ctr_e'(c + 2'd1);
        end else begin
            if (c != CTR_SNT)
                n = ctr_e'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// 2-bit saturating direction counters: one async read port,
// one write port that either steps a counter or loads a fresh value.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output ctr_e             o_rd_ctr,
    input  logic             i_wr_en,
    input  logic             i_wr_load,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken,
    input  ctr_e             i_wr_val
);

    ctr_e ctr_q [ENTRIES];
    ctr_e wr_d;

    assign o_rd_ctr = ctr_q[i_rd_idx];

    always_comb begin
        wr_d = ctr_step(ctr_q[i_wr_idx], i_wr_taken);
        if (i_wr_load)
            wr_d = i_wr_val;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr_q[i] <= CTR_WNT;
        end else if (i_wr_en) begin
            ctr_q[i_wr_idx] <= wr_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and delay-slot fall-through.
// Define BP_GSHARE_EN to index the counters by PC index XOR global history.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8,
    parameter int GHR_BITS = 6
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic [31:0] i_fetch_pc,
    output logic        o_hit,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_uncond
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_LSB = IDX_W + 2;

    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  unc_q;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [31:0]         tgt_q [ENTRIES];

    logic [IDX_W-1:0]    f_idx, u_idx;
    logic [IDX_W-1:0]    f_cidx, u_cidx;
    logic [TAG_BITS-1:0] f_tag, u_tag;
    logic                u_match, upd_hit, upd_alloc;
    ctr_e                f_ctr, alloc_ctr;

    assign f_idx = IDX_W'(pc_field(i_fetch_pc, 2, IDX_W));
    assign u_idx = IDX_W'(pc_field(i_upd_pc, 2, IDX_W));
    assign f_tag = TAG_BITS'(pc_field(i_fetch_pc, TAG_LSB, TAG_BITS));
    assign u_tag = TAG_BITS'(pc_field(i_upd_pc, TAG_LSB, TAG_BITS));

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;

    assign ghr_d  = GHR_BITS'({ghr_q, i_upd_taken});
    assign f_cidx = f_idx ^ IDX_W'(ghr_q);
    assign u_cidx = u_idx ^ IDX_W'(ghr_q);

    // Flush discards the update, history included.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            ghr_q <= '0;
        else if (i_upd_valid && !i_upd_uncond && !i_flush)
            ghr_q <= ghr_d;
    end
`else
    assign f_cidx = f_idx;
    assign u_cidx = u_idx;
`endif

    assign o_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign o_pred_taken = o_hit && (f_ctr[1] || unc_q[f_idx]);
    assign o_pred_target = o_pred_taken ? tgt_q[f_idx]
                                        : i_fetch_pc + FALL_THRU_OFS;

    assign u_match   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign upd_hit   = i_upd_valid && !i_flush && u_match;
    assign upd_alloc = i_upd_valid && !i_flush && !u_match && i_upd_taken;
    assign alloc_ctr = i_upd_uncond ? CTR_ST : CTR_WT;

    bp_counter_table #(
        .ENTRIES (ENTRIES)
    ) u_ctr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rd_idx   (f_cidx),
        .o_rd_ctr   (f_ctr),
        .i_wr_en    (upd_hit || upd_alloc),
        .i_wr_load  (upd_alloc),
        .i_wr_idx   (u_cidx),
        .i_wr_taken (i_upd_taken),
        .i_wr_val   (alloc_ctr)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            unc_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (i_flush) begin
            valid_q <= '0;
        end else if (upd_hit) begin
            unc_q[u_idx] <= i_upd_uncond;
            if (i_upd_taken)
                tgt_q[u_idx] <= i_upd_target;
        end else if (upd_alloc) begin
            valid_q[u_idx] <= 1'b1;
            unc_q[u_idx]   <= i_upd_uncond;
            tag_q[u_idx]   <= u_tag;
            tgt_q[u_idx]   <= i_upd_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default ENTRIES=64, TAG_BITS=8).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] fetch_pc;
    logic        hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_uncond;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (flush),
        .i_fetch_pc    (fetch_pc),
        .o_hit         (hit),
        .o_pred_taken  (pred_taken),
        .o_pred_target (pred_target),
        .i_upd_valid   (upd_valid),
        .i_upd_pc      (upd_pc),
        .i_upd_taken   (upd_taken),
        .i_upd_target  (upd_target),
        .i_upd_uncond  (upd_uncond)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic e_hit, input logic e_tk,
                          input logic [31:0] e_tgt);
        fetch_pc = pc;
        #1;
        check({tag, ".hit"}, 32'(hit), 32'(e_hit));
        check({tag, ".taken"}, 32'(pred_taken), 32'(e_tk));
        check({tag, ".target"}, pred_target, e_tgt);
    endtask

    task automatic update(input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic unc);
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        upd_uncond = unc;
        @(negedge clk);
        upd_valid  = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        fetch_pc   = 32'h0040_0000;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        upd_uncond = 1'b0;

        lookup("rst", 32'h0040_0000, 1'b0, 1'b0, 32'h0040_0008);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lookup("post_rst", 32'h0040_0000, 1'b0, 1'b0, 32'h0040_0008);

        update(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
        lookup("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);

        // 2 -> 1 -> 0; not-taken must not overwrite the target
        update(32'h0040_0010, 1'b0, 32'hDEAD_0000, 1'b0);
        update(32'h0040_0010, 1'b0, 32'hDEAD_0000, 1'b0);
        lookup("nt2", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0018);
        for (int i = 0; i < 3; i++)
            update(32'h0040_0010, 1'b0, 32'hDEAD_0000, 1'b0);
        lookup("sat0", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0018);
        update(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
        lookup("ctr1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0018);
        update(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b0);
        lookup("retarget", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);

        // 2 -> 3 -> 3, then 3 -> 2 (taken) -> 1 (not-taken)
        update(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b0);
        update(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b0);
        update(32'h0040_0010, 1'b0, 32'h0, 1'b0);
        lookup("sat3a", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);
        update(32'h0040_0010, 1'b0, 32'h0, 1'b0);
        lookup("sat3b", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0018);

        @(negedge clk);
        fetch_pc   = 32'h0040_0020;
        upd_valid  = 1'b1;
        upd_pc     = 32'h0040_0020;
        upd_taken  = 1'b1;
        upd_target = 32'h0040_0300;
        upd_uncond = 1'b0;
        #1;
        check("same_cyc.hit", 32'(hit), 32'd0);
        @(negedge clk);
        upd_valid = 1'b0;
        lookup("same_nxt", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0300);

        update(32'h0040_0000, 1'b1, 32'h0040_1000, 1'b0);
        update(32'h0040_0100, 1'b1, 32'h0040_2000, 1'b0);
        lookup("alias_old", 32'h0040_0000, 1'b0, 1'b0, 32'h0040_0008);
        lookup("alias_new", 32'h0040_0100, 1'b1, 1'b1, 32'h0040_2000);

        update(32'h0040_0040, 1'b1, 32'h0040_5000, 1'b1);
        update(32'h0040_0040, 1'b0, 32'h0, 1'b1);
        update(32'h0040_0040, 1'b0, 32'h0, 1'b1);
        lookup("uncond", 32'h0040_0040, 1'b1, 1'b1, 32'h0040_5000);
        update(32'h0040_0040, 1'b0, 32'h0, 1'b0);
        lookup("uncond_clr", 32'h0040_0040, 1'b1, 1'b0, 32'h0040_0048);

        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0004);

        @(negedge clk);
        flush      = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h0040_0080;
        upd_taken  = 1'b1;
        upd_target = 32'h0040_0900;
        upd_uncond = 1'b0;
        @(negedge clk);
        flush     = 1'b0;
        upd_valid = 1'b0;
        lookup("fl_a", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0018);
        lookup("fl_b", 32'h0040_0100, 1'b0, 1'b0, 32'h0040_0108);
        lookup("fl_upd", 32'h0040_0080, 1'b0, 1'b0, 32'h0040_0088);
        update(32'h0040_0010, 1'b1, 32'h0040_0700, 1'b0);
        lookup("realloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0700);

        // Reset lands mid-cycle while an update is pending
        @(negedge clk);
        fetch_pc   = 32'h0040_0010;
        upd_valid  = 1'b1;
        upd_pc     = 32'h0040_0030;
        upd_taken  = 1'b1;
        upd_target = 32'h0040_0A00;
        upd_uncond = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.hit", 32'(hit), 32'd0);
        @(negedge clk);
        upd_valid = 1'b0;
        rst_n     = 1'b1;
        lookup("rst_lost", 32'h0040_0030, 1'b0, 1'b0, 32'h0040_0038);
        lookup("rst_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0018);

`ifdef BP_GSHARE_EN
        update(32'h0040_0050, 1'b1, 32'h0040_0B00, 1'b0);
        update(32'h0040_0054, 1'b1, 32'h0040_0B00, 1'b0);
        update(32'h0040_0058, 1'b1, 32'h0040_0B00, 1'b0);
        check("ghr", 32'(dut.ghr_q), 32'h0000_0007);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, 64, number of BTB/counter entries; power of two, 4..1024.
REQ-002 Parameter TAG_BITS, 8, stored tag width taken from PC bits above the index.
REQ-003 Parameter GHR_BITS, 6, global history length; GHR_BITS <= log2(ENTRIES).
REQ-004 Port i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port i_flush  in  1  invalidate all BTB entries.
REQ-007 Port i_fetch_pc  in  32  PC being fetched.
REQ-008 Port o_hit  out  1  valid tag match for i_fetch_pc.
REQ-009 Port o_pred_taken  out  1  predicted taken.
REQ-010 Port o_pred_target  out  32  predicted next PC.
REQ-011 Port i_upd_valid  in  1  a branch/jump resolved this cycle.
REQ-012 Port i_upd_pc  in  32  PC of the resolved branch.
REQ-013 Port i_upd_taken  in  1  actual direction.
REQ-014 Port i_upd_target  in  32  actual taken target.
REQ-015 Port i_upd_uncond  in  1  J/JAL/JR/JALR (always taken).

Function
REQ-016 Index = PC[log2(ENTRIES)+1:2]; tag = next TAG_BITS PC bits above the index.
REQ-017 Lookup purely combinational: o_hit = valid & tag match at indexed entry.
REQ-018 o_pred_taken = o_hit & (counter[1] | entry uncond flag).
REQ-019 o_pred_target = stored target if o_pred_taken, else i_fetch_pc + 8 (delay-slot fall-through), 32-bit wrap.
REQ-020 Counter: 2-bit saturating; taken increments to max 3, not-taken decrements to min 0.
REQ-021 Update hit: counter adjusted; target overwritten only when i_upd_taken; uncond flag set to i_upd_uncond.
REQ-022 Update miss and taken: allocate entry (valid=1, new tag, target), counter = 2 (weakly taken), or 3 if uncond.
REQ-023 Update miss and not-taken: no allocation, table unchanged.
REQ-024 Lookup and update in same cycle to the same index: lookup returns pre-update contents; update visible next cycle.
REQ-025 i_flush and i_upd_valid together: flush wins; all valid bits 0 next cycle, update discarded; counters and GHR untouched.
REQ-026 Latency: update written at the rising edge of the cycle it is presented; no stall or backpressure.

Reset
REQ-027 On i_rst_n low: all valid bits 0, all counters 1 (weakly not-taken), all uncond flags 0, GHR 0, immediately without clock.
REQ-028 During and after reset until first allocation: o_hit=0, o_pred_taken=0, o_pred_target=i_fetch_pc+8.
REQ-029 Reset asserted mid-update: the update is lost; state equals REQ-027 on deassertion.

Configuration
REQ-030 Macro BP_GSHARE_EN defined: counter index = PC index XOR (GHR zero-extended); BTB index/tag unchanged; GHR shifts left inserting i_upd_taken on every i_upd_valid conditional (non-uncond) branch.
REQ-031 Macro undefined: counters indexed by PC index only; no GHR register is instantiated.

Structure
REQ-032 Shared package bp_pkg holds the 2-bit counter encodings (SNT=0, WNT=1, WT=2, ST=3), the fall-through offset constant 8, and the index/tag slicing helper.
REQ-033 One sub-module bp_counter_table (counter array + saturating update logic) is instantiated; BTB tag/target/valid arrays stay in the top.

Verification
REQ-034 Reset, lookup pc 0x00400000 -> o_hit=0, o_pred_taken=0, o_pred_target=0x00400008.
REQ-035 Update pc 0x00400010 taken target 0x00400100, then lookup 0x00400010 -> hit, taken, target 0x00400100.
REQ-036 Same branch updated not-taken twice -> counter 2->1->0; lookup gives hit, not-taken, target 0x00400018; three further not-taken keep counter 0.
REQ-037 Same-cycle lookup and taken update to unallocated 0x00400020 -> that cycle o_hit=0; next cycle hit, taken.
REQ-038 ENTRIES=64: pcs 0x00400000 and 0x00400100 (same index, different tag) allocated in turn -> first lookup now misses, second hits.
REQ-039 i_flush with i_upd_valid taken to new pc -> next cycle every lookup misses; with BP_GSHARE_EN, GHR after three taken conditional updates equals 0b000111.
